// File: rtl/add_comp_mux_pkg.sv
// ============================================================================
// Module      : add_comp_mux_pkg
// Description : Shared width default and compare-result type for add_comp_mux_dp.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package add_comp_mux_pkg;

   localparam int DATAWIDTH_DEF = 32;

   typedef struct packed {
      logic lt;
      logic eq;
      logic gt;
   } cmp_res_t;

endpackage

`default_nettype wire

// File: rtl/add_comp_mux_cmp.sv
// ============================================================================
// Module      : add_comp_mux_cmp
// Description : Three-way comparator; signed when ADD_COMP_MUX_SIGNED_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_comp_mux_cmp
   import add_comp_mux_pkg::*;
#(
   parameter int DATAWIDTH = DATAWIDTH_DEF
) (
   input  logic [DATAWIDTH-1:0] i_x,
   input  logic [DATAWIDTH-1:0] i_y,
   output cmp_res_t             o_res
);

   logic w_lt;
   logic w_eq;

`ifdef ADD_COMP_MUX_SIGNED_EN
   assign w_lt = $signed(i_x) < $signed(i_y);
`else
   assign w_lt = i_x < i_y;
`endif
   assign w_eq = (i_x == i_y);

   // gt derived from the other two keeps the result strictly one-hot
   assign o_res.lt = w_lt;
   assign o_res.eq = w_eq;
   assign o_res.gt = ~w_lt & ~w_eq;

endmodule

`default_nettype wire

// File: rtl/add_comp_mux_dp.sv
// ============================================================================
// Module      : add_comp_mux_dp
// Description : Registered d=a+b, e=a+c, three-way compare and min-select.
//               Compare signedness selected by macro ADD_COMP_MUX_SIGNED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_comp_mux_dp
   import add_comp_mux_pkg::*;
#(
   parameter int DATAWIDTH = DATAWIDTH_DEF
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 in_valid,
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   input  logic [DATAWIDTH-1:0] c,
   output logic [DATAWIDTH-1:0] d,
   output logic [DATAWIDTH-1:0] e,
   output logic                 dLTe,
   output logic                 dEQe,
   output logic                 dGTe,
   output logic [DATAWIDTH-1:0] g,
   output logic                 out_valid
);

   logic [DATAWIDTH-1:0] w_d;
   logic [DATAWIDTH-1:0] w_e;
   logic [DATAWIDTH-1:0] w_g;
   cmp_res_t             w_cmp;

   logic [DATAWIDTH-1:0] r_d;
   logic [DATAWIDTH-1:0] r_e;
   logic [DATAWIDTH-1:0] r_g;
   logic                 r_lt;
   logic                 r_eq;
   logic                 r_gt;
   logic                 r_out_valid;

   // carry discarded: sums wrap modulo 2^DATAWIDTH
   assign w_d = a + b;
   assign w_e = a + c;

   add_comp_mux_cmp #(
      .DATAWIDTH (DATAWIDTH)
   ) u_cmp (
      .i_x   (w_d),
      .i_y   (w_e),
      .o_res (w_cmp)
   );

   assign w_g = w_cmp.lt ? w_d : w_e;

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         r_d         <= '0;
         r_e         <= '0;
         r_g         <= '0;
         r_lt        <= 1'b0;
         r_eq        <= 1'b1;
         r_gt        <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_d  <= w_d;
            r_e  <= w_e;
            r_g  <= w_g;
            r_lt <= w_cmp.lt;
            r_eq <= w_cmp.eq;
            r_gt <= w_cmp.gt;
         end
      end
   end

   assign d         = r_d;
   assign e         = r_e;
   assign g         = r_g;
   assign dLTe      = r_lt;
   assign dEQe      = r_eq;
   assign dGTe      = r_gt;
   assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_add_comp_mux_dp.sv
// ============================================================================
// Module      : tb_add_comp_mux_dp
// Description : Self-checking bench for add_comp_mux_dp (directed + random).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add_comp_mux_dp;

   localparam int W = 32;

   logic         Clk;
   logic         Rst;
   logic         in_valid;
   logic [W-1:0] a, b, c;
   logic [W-1:0] d, e, g;
   logic         dLTe, dEQe, dGTe, out_valid;

   int n_total = 0;
   int n_bad   = 0;

   // reference state: what the outputs should show after the last edge
   logic [W-1:0] m_d, m_e, m_g;
   logic         m_lt, m_eq, m_gt, m_ov;

   add_comp_mux_dp #(.DATAWIDTH(W)) u_dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .c         (c),
      .d         (d),
      .e         (e),
      .dLTe      (dLTe),
      .dEQe      (dEQe),
      .dGTe      (dGTe),
      .g         (g),
      .out_valid (out_valid)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic less(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef ADD_COMP_MUX_SIGNED_EN
      return $signed(x) < $signed(y);
`else
      return x < y;
`endif
   endfunction

   task automatic model(input logic rst_n, input logic v,
                        input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] ic);
      longint unsigned sd, se;
      if (!rst_n) begin
         m_d = '0; m_e = '0; m_g = '0;
         m_lt = 1'b0; m_eq = 1'b1; m_gt = 1'b0; m_ov = 1'b0;
      end else begin
         m_ov = v;
         if (v) begin
            sd   = (longint'(ia) + longint'(ib)) % (64'd1 << W);
            se   = (longint'(ia) + longint'(ic)) % (64'd1 << W);
            m_d  = sd[W-1:0];
            m_e  = se[W-1:0];
            m_lt = less(m_d, m_e);
            m_eq = (m_d == m_e);
            m_gt = less(m_e, m_d);
            m_g  = less(m_d, m_e) ? m_d : m_e;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".d"},   64'(d),         64'(m_d));
      chk({tag, ".e"},   64'(e),         64'(m_e));
      chk({tag, ".g"},   64'(g),         64'(m_g));
      chk({tag, ".lt"},  64'(dLTe),      64'(m_lt));
      chk({tag, ".eq"},  64'(dEQe),      64'(m_eq));
      chk({tag, ".gt"},  64'(dGTe),      64'(m_gt));
      chk({tag, ".ov"},  64'(out_valid), 64'(m_ov));
   endtask

   task automatic step(input string tag, input logic rst_n, input logic v,
                       input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] ic);
      Rst = rst_n; in_valid = v; a = ia; b = ib; c = ic;
      @(posedge Clk);
      model(rst_n, v, ia, ib, ic);
      #1;
      check_all(tag);
   endtask

   initial begin
      logic [W-1:0] ra, rb, rc;
      logic         rv, rr;
      Rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; c = '0;

      step("rst0", 1'b0, 1'b0, '0, '0, '0);
      step("rst1", 1'b0, 1'b1, 32'd7, 32'd1, 32'd2);
      chk("rst_eq", 64'(dEQe), 64'd1);

      step("lt", 1'b1, 1'b1, 32'd5, 32'd3, 32'd10);
      chk("lt_d", 64'(d), 64'd8);
      chk("lt_e", 64'(e), 64'd15);
      chk("lt_g", 64'(g), 64'd8);
      chk("lt_flag", 64'(dLTe), 64'd1);

      for (int i = 0; i < 3; i++) begin
         step("hold", 1'b1, 1'b0, $urandom, $urandom, $urandom);
         chk("hold_g", 64'(g), 64'd8);
         chk("hold_ov", 64'(out_valid), 64'd0);
      end

      step("eq", 1'b1, 1'b1, 32'd4, 32'd6, 32'd6);
      chk("eq_g", 64'(g), 64'd10);
      chk("eq_flag", 64'(dEQe), 64'd1);

      step("wrap", 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'd0);
      chk("wrap_d", 64'(d), 64'd1);
      chk("wrap_e", 64'(e), 64'hFFFF_FFFF);
`ifdef ADD_COMP_MUX_SIGNED_EN
      chk("wrap_g", 64'(g), 64'hFFFF_FFFF);
      chk("wrap_gt", 64'(dGTe), 64'd1);
`else
      chk("wrap_g", 64'(g), 64'd1);
      chk("wrap_lt", 64'(dLTe), 64'd1);
`endif

      // continuous stream with a single reset cycle in the middle
      for (int i = 0; i < 8; i++) begin
         step("midrst", (i == 4) ? 1'b0 : 1'b1, 1'b1, $urandom, $urandom, $urandom);
      end

      for (int i = 0; i < 400; i++) begin
         ra = $urandom; rb = $urandom; rc = $urandom;
         if ($urandom_range(0, 7) == 0) rc = rb;
         if ($urandom_range(0, 7) == 0) begin ra = $urandom_range(0, 15); rb = $urandom_range(0, 15); rc = $urandom_range(0, 15); end
         rv = ($urandom_range(0, 3) != 0);
         rr = ($urandom_range(0, 39) != 0);
         step("rnd", rr, rv, ra, rb, rc);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/add_comp_mux_dp.md
ADD_COMP_MUX_DP -- requirements
Module: add_comp_mux_dp

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, meaning the operand and result width in bits (legal range 2..64).
REQ-002 SHALL have port Clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port Rst, input, 1 bit; reset is synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit; when high, a, b and c are sampled this cycle.
REQ-005 SHALL have ports a, b and c, input, DATAWIDTH bits each, the operands.
REQ-006 SHALL have port d, output, DATAWIDTH bits; registered a+b.
REQ-007 SHALL have port e, output, DATAWIDTH bits; registered a+c.
REQ-008 SHALL have ports dLTe, dEQe and dGTe, output, 1 bit each; registered comparison of d against e.
REQ-009 SHALL have port g, output, DATAWIDTH bits; registered mux result, the minimum of d and e.
REQ-010 SHALL have port out_valid, output, 1 bit; high for exactly one cycle per accepted input.

Function
REQ-011 SHALL compute d=a+b and e=a+c modulo 2^DATAWIDTH, discarding the carry.
REQ-012 SHALL compare the unregistered sums: lt=(d<e), eq=(d==e), gt=(d>e); exactly one of the three is high.
REQ-013 SHALL select g as follows: g=d when lt=1, otherwise g=e; on equality g=e (equal value).
REQ-014 SHALL register d, e, lt, eq, gt and g on a rising Clk edge with in_valid=1 and Rst=1, giving latency exactly 1 cycle.
REQ-015 SHALL hold all data outputs unchanged while in_valid=0.
REQ-016 SHALL set out_valid=1 in the cycle after an accepted input and 0 otherwise.
REQ-017 SHALL accept back-to-back inputs every cycle; there is no backpressure.
REQ-018 SHALL have no combinational path from any input to any output.

Reset
REQ-019 SHALL, on a rising Clk edge with Rst=0, clear d, e, g, dLTe, dGTe and out_valid to 0 and set dEQe to 1, consistent with d==e==0.
REQ-020 SHALL give reset priority over in_valid; an input presented in a reset cycle is dropped.
REQ-021 SHALL make outputs undefined before the first reset edge; this is permitted behaviour.

Configuration
REQ-022 SHALL define the comparison signedness with macro ADD_COMP_MUX_SIGNED_EN.
REQ-023 SHALL, with ADD_COMP_MUX_SIGNED_EN defined, perform the comparison and min-select in two's-complement signed arithmetic.
REQ-024 SHALL, without ADD_COMP_MUX_SIGNED_EN, perform the comparison and min-select unsigned.
REQ-025 SHALL leave addition unaffected by the macro, since the bit result is identical either way.

Structure
REQ-026 SHALL place in a shared package add_comp_mux_pkg: the DATAWIDTH default constant and a typedef for the compare-result struct {lt, eq, gt}.
REQ-027 SHALL implement the three-way comparator as one sub-module, add_comp_mux_cmp, parameterized by DATAWIDTH, which honours the macro.
REQ-028 SHALL implement adders and mux inline in the top module.

Verification
REQ-029 SHALL cover reset: Rst=0 for 2 cycles -> d=e=g=0, dEQe=1, dLTe=dGTe=0, out_valid=0.
REQ-030 SHALL cover the less-than case (W=32): a=5, b=3, c=10, in_valid=1 -> next cycle d=8, e=15, dLTe=1, g=8, out_valid=1.
REQ-031 SHALL cover the equal case: a=4, b=6, c=6 -> d=10, e=10, dEQe=1, dLTe=0, g=10.
REQ-032 SHALL cover wrap and signedness: a=0xFFFFFFFF, b=2, c=0 -> d=1, e=0xFFFFFFFF.
- Unsigned build: dLTe=1, g=1.
- Signed build: dGTe=1, g=0xFFFFFFFF.
REQ-033 SHALL cover a hold: in_valid=0 for 3 cycles after the REQ-030 vector -> outputs stay at the REQ-030 values, out_valid=0 after the first cycle.
REQ-034 SHALL cover reset mid-stream: continuous in_valid=1, Rst=0 for one cycle -> outputs at reset values the next cycle, then the stream resumes with 1-cycle latency.
